// File: rtl/pc_pkg.sv
// Shared constants and the half-width incrementer used by both PC halves.
package pc_pkg;

    localparam int BUS_W_DEF = 8;
    localparam logic [15:0] RESET_VEC_DEF = 16'hFFFC;

    // Widest half the incrementer supports; the carry sits one bit above it.
    localparam int HALF_MAX_W = 32;

    // Returns {carry, sum}: the carry is the bit just above the 'width'-bit
    // half, so one function serves any BUS_W up to HALF_MAX_W-1.
    function automatic logic [HALF_MAX_W:0] half_inc(
        input logic [HALF_MAX_W-1:0] value,
        input logic                  inc,
        input logic [5:0]            width
    );
        logic [HALF_MAX_W:0] full;
        full = {1'b0, value} + {{HALF_MAX_W{1'b0}}, inc};
        return {full[width], full[HALF_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/pc_half.sv
// One half of the program counter: source mux, incrementer and register.
module pc_half
    import pc_pkg::*;
#(
    parameter int BUS_W = BUS_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BUS_W-1:0] RST_VAL,
    input  logic             LOAD_EXT,
    input  logic [BUS_W-1:0] EXT_DATA,
    input  logic             CIN,
    output logic [BUS_W-1:0] Q,
    output logic             COUT
);

    logic [BUS_W-1:0]    r_q;
    logic [BUS_W-1:0]    w_sel;
    logic [HALF_MAX_W:0] w_res;
    logic [BUS_W-1:0]    w_sum;
    logic                w_unused_upper;

    assign w_sel = LOAD_EXT ? EXT_DATA : r_q;
    assign w_res = half_inc(HALF_MAX_W'(w_sel), CIN, 6'(BUS_W));
    assign w_sum = w_res[BUS_W-1:0];

    // Bits between the half and the carry position only ever hold the spill.
    assign w_unused_upper = ^w_res[HALF_MAX_W-1:BUS_W];

    assign COUT = w_res[HALF_MAX_W];
    assign Q    = r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_sum;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter: two chained halves, a low-half carry flag and bus drivers.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                BUS_W     = BUS_W_DEF,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PCL_ADL_LOAD,
    input  logic              PCH_ADH_LOAD,
    input  logic              PC_INC,
    input  logic [BUS_W-1:0]  ADL_DATA,
    input  logic [BUS_W-1:0]  ADH_DATA,
    input  logic              DB_PCL_EN,
    input  logic              DB_PCH_EN,
    input  logic              ADL_PCL_EN,
    input  logic              ADH_PCH_EN,
    output logic [BUS_W-1:0]  DB_BUS,
    output logic [BUS_W-1:0]  ADL_BUS,
    output logic [BUS_W-1:0]  ADH_BUS,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              PCL_CARRY,
    output logic              DB_CONFLICT
);

    if (ADDR_W != 2 * BUS_W) begin : g_width_check
        $error("pc_unit: ADDR_W must equal 2*BUS_W");
    end

    logic [BUS_W-1:0] w_pcl;
    logic [BUS_W-1:0] w_pch;
    logic             w_lo_cout;
    logic             w_unused_hi_cout;
    logic             r_pcl_carry;

    pc_half #(.BUS_W(BUS_W)) u_lo (
        .CLK      (CLK),
        .RST      (RST),
        .RST_VAL  (RESET_VEC[BUS_W-1:0]),
        .LOAD_EXT (PCL_ADL_LOAD),
        .EXT_DATA (ADL_DATA),
        .CIN      (PC_INC),
        .Q        (w_pcl),
        .COUT     (w_lo_cout)
    );

    // The high half's carry-in is the low half's carry-out, not PC_INC.
    pc_half #(.BUS_W(BUS_W)) u_hi (
        .CLK      (CLK),
        .RST      (RST),
        .RST_VAL  (RESET_VEC[ADDR_W-1:BUS_W]),
        .LOAD_EXT (PCH_ADH_LOAD),
        .EXT_DATA (ADH_DATA),
        .CIN      (w_lo_cout),
        .Q        (w_pch),
        .COUT     (w_unused_hi_cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pcl_carry <= 1'b0;
        end else begin
            r_pcl_carry <= w_lo_cout;
        end
    end

    assign PC_OUT    = {w_pch, w_pcl};
    assign PCL_CARRY = r_pcl_carry;

    // Disabled drivers output zero so buses can be OR-merged; PCL wins on DB.
    assign DB_BUS      = DB_PCL_EN ? w_pcl : (DB_PCH_EN ? w_pch : '0);
    assign ADL_BUS     = ADL_PCL_EN ? w_pcl : '0;
    assign ADH_BUS     = ADH_PCH_EN ? w_pch : '0;
    assign DB_CONFLICT = DB_PCL_EN & DB_PCH_EN;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised, clocked program counter replacing the separate PCLS/PCL select and hold registers.
- Holds a 2*BUS_W program counter and selects each half from either its own loop-back value or the address buses (ADL/ADH).
- Increments with carry propagation from the low half into the high half.
- Drives the DB, ADL and ADH buses under individual enables.
- Sits between the timing/decode control lines and the internal address/data buses of the CPU core.

Parameters:
- BUS_W, 8, width of one bus and of each PC half.
- ADDR_W, 16, full PC width; must equal 2*BUS_W (elaboration error otherwise).
- RESET_VEC, 16'hFFFC, value loaded into the PC on reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PCL_ADL_LOAD  in  1  low-half source = ADL_DATA (else PCL loop-back).
- PCH_ADH_LOAD  in  1  high-half source = ADH_DATA (else PCH loop-back).
- PC_INC  in  1  increment the selected value by 1.
- ADL_DATA  in  BUS_W  ADL bus input.
- ADH_DATA  in  BUS_W  ADH bus input.
- DB_PCL_EN  in  1  drive PCL onto DB_BUS.
- DB_PCH_EN  in  1  drive PCH onto DB_BUS.
- ADL_PCL_EN  in  1  drive PCL onto ADL_BUS.
- ADH_PCH_EN  in  1  drive PCH onto ADH_BUS.
- DB_BUS  out  BUS_W  data bus output.
- ADL_BUS  out  BUS_W  address-low bus output.
- ADH_BUS  out  BUS_W  address-high bus output.
- PC_OUT  out  ADDR_W  current PC, for debug and the address latch.
- PCL_CARRY  out  1  registered flag: the last update wrapped the low half.
- DB_CONFLICT  out  1  combinational: DB_PCL_EN and DB_PCH_EN both high.

Behaviour:
- Reset, synchronous, takes priority over every other input:
  - PC <= RESET_VEC and PCL_CARRY <= 0.
  - With all enables low, outputs are DB_BUS = ADL_BUS = ADH_BUS = 0 and DB_CONFLICT = 0.
- Every non-reset rising edge:
  - sel_lo = PCL_ADL_LOAD ? ADL_DATA : PC[BUS_W-1:0]
  - sel_hi = PCH_ADH_LOAD ? ADH_DATA : PC[ADDR_W-1:BUS_W]
  - {c, lo} = sel_lo + PC_INC, computed BUS_W+1 wide.
  - hi = sel_hi + c, modulo 2^BUS_W.
  - PC <= {hi, lo} and PCL_CARRY <= c.
- When all controls are low, the PC holds its value and PCL_CARRY is cleared to 0.
- Load and increment in the same cycle is legal: the result is the loaded value + 1 (JMP/vector fetch pattern).
- Wrap-around: PC 16'hFFFF with PC_INC gives 16'h0000 and PCL_CARRY = 1. There is no overflow error.
- Bus outputs are combinational from the registered PC, i.e. the pre-edge value, so a value driven in cycle n reflects updates up to edge n-1.
  - A disabled bus output drives all zeros, so it can be OR-combined with other bus sources.
  - DB_BUS priority: PCL if DB_PCL_EN, else PCH if DB_PCH_EN, else 0.
  - DB_CONFLICT = DB_PCL_EN & DB_PCH_EN. When it is high, PCL still wins.
- Latency:
  - Load or increment to PC_OUT: 1 cycle.
  - Enable to bus: 0 cycles.
- Reset asserted during a load or increment: the load/increment is discarded and the PC becomes RESET_VEC.
- Inputs are sampled only at the clock edge. There are no level-sensitive latches; every stored bit is a flip-flop.

Decomposition:
- Shared package pc_pkg:
  - localparams BUS_W_DEF = 8 and RESET_VEC_DEF = 16'hFFFC.
  - Function half_inc(value, inc), returning {carry, sum}.
- Sub-module pc_half, instanced twice (low and high):
  - Holds one BUS_W register with a source mux and an incrementer.
  - Ports: CLK, RST, RST_VAL, LOAD_EXT, EXT_DATA, CIN, Q, COUT.
  - For the low half, CIN = PC_INC; for the high half, CIN = COUT of the low half.
- pc_unit wraps both halves, the PCL_CARRY flop and the bus output muxes.

Test Plan:
1. Assert RST for 1 cycle, all enables low -> PC_OUT = 16'hFFFC, PCL_CARRY = 0, all buses 0, DB_CONFLICT = 0.
2. After reset, PC_INC high for 5 cycles -> PC_OUT steps FFFD, FFFE, FFFF, 0000 (PCL_CARRY = 1 for this update only), 0001 (PCL_CARRY back to 0).
3. ADL_DATA = 8'h34, ADH_DATA = 8'h12, both LOAD high, PC_INC low -> PC_OUT = 16'h1234 next cycle. ADL_PCL_EN + ADH_PCH_EN -> ADL_BUS = 8'h34, ADH_BUS = 8'h12.
4. Load 16'h12FF with PC_INC high in the same cycle -> PC_OUT = 16'h1300, PCL_CARRY = 1. A following idle cycle -> PC holds 16'h1300, PCL_CARRY = 0.
5. PC = 16'hABCD, DB_PCL_EN and DB_PCH_EN both high -> DB_BUS = 8'hCD, DB_CONFLICT = 1. With only DB_PCH_EN -> DB_BUS = 8'hAB, DB_CONFLICT = 0.
6. RST asserted in the same cycle as a load of 16'h5555 with PC_INC -> PC_OUT = 16'hFFFC next cycle, PCL_CARRY = 0. Repeat with BUS_W = 4, ADDR_W = 8, RESET_VEC = 8'hF0 -> increment 8'hFF wraps to 8'h00 with PCL_CARRY = 1.
